// File: rtl/alu_pkg.sv
// Shared ALU definitions: MIPS ALU-control encodings, serial FSM states, default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aluState_e;

  function automatic logic isArith(input aluOp_e op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/adder.sv
// 1-bit full-adder cell shared by every arithmetic bit of the serial ALU.
module adder (
  input  logic a,
  input  logic b,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);

  assign Sum      = a ^ b ^ CarryIn;
  assign CarryOut = (a & b) | (CarryIn & (a ^ b));

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU execute stage: one operand bit per cycle, LSB first, through a single adder cell.
// Optional SERIAL_ALU_SLT_EN: op 111 produces a set-less-than word; otherwise it executes as SUB.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  aluState_e        state;
  aluOp_e           opReg;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] resSh;
  logic             carryFf;
  logic [CW-1:0]    bitCnt;

  logic             sum;
  logic             cellCarry;
  logic             bitRes;
  logic             bitOvf;
  logic [WIDTH-1:0] finalWord;
  logic [WIDTH-1:0] outWord;
  aluOp_e           opDec;
  logic             subtract;

  adder uAdder (
    .a       (aSh[0]),
    .b       (bSh[0]),
    .CarryIn (carryFf),
    .Sum     (sum),
    .CarryOut(cellCarry)
  );

  // Undefined codes collapse to AND at accept so the datapath only ever sees legal ops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    opDec = ALU_AND;
    case (op)
      3'b001:  opDec = ALU_OR;
      3'b010:  opDec = ALU_ADD;
      3'b110:  opDec = ALU_SUB;
`ifdef SERIAL_ALU_SLT_EN
      3'b111:  opDec = ALU_SLT;
`else
      3'b111:  opDec = ALU_SUB;
`endif
      default: opDec = ALU_AND;
    endcase
  end

  assign subtract = (opDec == ALU_SUB) || (opDec == ALU_SLT);

  always_comb begin
    bitRes = sum;
    case (opReg)
      ALU_AND: bitRes = aSh[0] & bSh[0];
      ALU_OR:  bitRes = aSh[0] | bSh[0];
      default: bitRes = sum;
    endcase
  end

  assign bitOvf    = carryFf ^ cellCarry;
  assign finalWord = {bitRes, resSh[WIDTH-1:1]};

`ifdef SERIAL_ALU_SLT_EN
  assign outWord = (opReg == ALU_SLT) ? {{(WIDTH-1){1'b0}}, sum ^ bitOvf} : finalWord;
`else
  assign outWord = finalWord;
`endif

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      opReg     <= ALU_AND;
      aSh       <= '0;
      bSh       <= '0;
      resSh     <= '0;
      carryFf   <= 1'b0;
      bitCnt    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aSh     <= a;
            bSh     <= subtract ? ~b : b;
            carryFf <= subtract;
            bitCnt  <= '0;
            opReg   <= opDec;
            state   <= RUN;
          end
        end
        RUN: begin
          resSh  <= finalWord;
          aSh    <= aSh >> 1;
          bSh    <= bSh >> 1;
          bitCnt <= bitCnt + CW'(1);
          if (isArith(opReg)) carryFf <= cellCarry;
          if (bitCnt == LAST_BIT) begin
            result    <= outWord;
            carry_out <= isArith(opReg) & cellCarry;
            overflow  <= isArith(opReg) & bitOvf;
            zero      <= (outWord == '0);
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32): directed test-plan cases plus random ops vs an arithmetic model.
module tb_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain wide arithmetic and signed comparison.
  function automatic exp_t model(input logic [2:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    case (code)
      3'b001: e.res = x | y;
      3'b010: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      3'b110, 3'b111: begin
        s     = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
`ifdef SERIAL_ALU_SLT_EN
        if (code == 3'b111) e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`endif
      end
      default: e.res = x & y;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic waitReady(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_readyWait"}, ready, 1);
  endtask

  // Runs one op; pulseAt > 0 raises start with junk operands at that RUN cycle.
  task automatic runOp(input string tag, input logic [2:0] code, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int pulseAt);
    exp_t e;
    int   n;
    logic got;
    e = model(code, x, y);
    waitReady(tag);
    @(negedge clk);
    op = code; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    check({tag, "_busy"}, {busy, ready}, 2'b10);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      start = (n == pulseAt);
      a = $urandom; b = $urandom; op = 3'($urandom);
      got = done;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, W);
    check({tag, "_result"}, result, e.res);
    check({tag, "_flags"}, {carry_out, overflow, zero}, {e.c, e.v, e.z});
    @(posedge clk);
    #1;
    check({tag, "_after"}, {done, ready, result}, {1'b0, 1'b1, e.res});
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic [2:0]   code;
    int           n;
    logic         sawDone;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {ready, busy, done}, 3'b100);
    check("reset_data", {result, carry_out, overflow, zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("add_ovf",  3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    runOp("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    runOp("sub_eq",   3'b110, 32'd5, 32'd5, 0);
    runOp("sub_neg",  3'b110, 32'd3, 32'd5, 0);
    runOp("and",      3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    runOp("or",       3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    runOp("slt",      3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    runOp("slt_ovf",  3'b111, 32'h8000_0000, 32'h0000_0001, 0);
    runOp("bad_op",   3'b101, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0);
    runOp("start_ign", 3'b010, 32'h1234_5678, 32'h1111_1111, 5);

    for (int i = 0; i < 40; i++) begin
      code = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 5 == 0) ? x : $urandom;
      if (i % 7 == 0) x = 32'h8000_0000;
      runOp($sformatf("rnd%0d", i), code, x, y, 0);
    end

    // Asynchronous reset in the middle of an operation.
    waitReady("rst");
    @(negedge clk);
    op = 3'b010; a = 32'h0000_00FF; b = 32'h0000_0001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {ready, busy, done}, 3'b100);
    check("rst_mid_data", {result, carry_out, overflow, zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      sawDone |= done;
      n++;
    end
    check("rst_no_done", sawDone, 1'b0);
    runOp("post_rst", 3'b110, 32'h0000_0000, 32'h0000_0001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial 32-bit ALU execute stage. It drives the 1-bit full-adder cell one operand bit per cycle, LSB first, holds the carry in a flip-flop between bits, and reassembles the sum into a word. The block sits between the decode/ALU-control logic, which supplies operands and a MIPS ALU-control code, and the writeback/branch logic, which consumes the result and flags. A start/ready/done handshake frames each operation.

## Interface
- `WIDTH`, 32, operand and result width; legal range 2..64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only on a rising edge where `ready`=1.
- `op`  in  3  ALU control code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (see Configuration). Any other code executes as AND.
- `a`  in  WIDTH  operand A; sampled with an accepted `start` only.
- `b`  in  WIDTH  operand B; sampled with an accepted `start` only.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  WIDTH  final word; held from `done` until the next accepted `start`.
- `carry_out`  out  1  carry out of the MSB for ADD/SUB/SLT; 0 for AND/OR.
- `overflow`  out  1  signed overflow for ADD/SUB/SLT; 0 for AND/OR.
- `zero`  out  1  `result`==0; valid from `done`, then held.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on accepted `start`.
  - RUN → DONE after the WIDTH-th bit.
  - DONE → IDLE unconditionally.
- On accept:
  - Latch `a` into shift register `a_sh`.
  - Latch `b` into `b_sh`, inverted when op is SUB or SLT.
  - Set carry FF to 1 for SUB/SLT, 0 otherwise.
  - Clear bit counter to 0.
  - Latch `op`.
- RUN cycle:
  - Present `a_sh[0]`, `b_sh[0]` and carry FF to the adder cell.
  - Bit result by op: AND → a&b, OR → a|b, arithmetic → Sum.
  - Shift the bit into the result register at the MSB (shift right); shift `a_sh` and `b_sh` right.
  - Carry FF ← CarryOut (arithmetic only).
  - Counter +1.
- Last bit (counter==WIDTH-1):
  - `carry_out` ← CarryOut.
  - `overflow` ← carry-in of that bit XOR CarryOut.
  - `zero` ← (final word==0).
- Arithmetic is modulo 2^WIDTH. Operands are two's complement for the overflow flag.
- `start` is ignored while not `ready`. No queuing.
- Reset (at any time, including mid-RUN) forces IDLE. The in-flight operation is discarded and no `done` is produced.
- Reset values:
  - `ready`=1.
  - `busy`=0, `done`=0, `result`=0, `carry_out`=0, `overflow`=0, `zero`=0.
  - Internal shift registers, carry FF and counter = 0.

## Timing
- Start accepted at edge E0. RUN spans edges E1..E_WIDTH; bit k is processed at E(k+1).
- State is DONE and `done`=1 in the cycle after E_WIDTH: latency WIDTH cycles from the accept edge.
- Flags and `result` are registered at E_WIDTH.
- `ready` returns high one cycle after `done`. Minimum issue interval is WIDTH+2 cycles.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.

## Configuration
- `SERIAL_ALU_SLT_EN` defined:
  - op 111 runs a full subtraction.
  - At E_WIDTH, `result` ← {WIDTH-1 zeros, (sign bit of difference XOR overflow)}.
  - `zero` reflects that final word.
- `SERIAL_ALU_SLT_EN` undefined: op 111 behaves exactly as SUB (110).

## Structure
- Shared package `alu_pkg`:
  - op encodings `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`;
  - FSM state enum;
  - default width constant.
- One sub-module: the existing 1-bit `adder` cell (a, b, CarryIn → Sum, CarryOut), instantiated once. The logic ops are muxed around it.

## Test plan
All scenarios use WIDTH=32.
- ADD 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `overflow`=1, `carry_out`=0, `zero`=0; `done` exactly 32 cycles after the accept edge.
- ADD 0xFFFFFFFF + 0x00000001 → `result`=0, `carry_out`=1, `overflow`=0, `zero`=1.
- SUB 5 − 5 → `result`=0, `carry_out`=1, `zero`=1. SUB 3 − 5 → 0xFFFFFFFE, `carry_out`=0.
- AND 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000. OR on the same operands → 0xFFF0FFF0. Both with `carry_out`=0 and `overflow`=0.
- SLT a=0xFFFFFFFF, b=1 → 0x00000001 with the macro; 0xFFFFFFFE without it.
- `start` pulsed at cycle 5 of RUN → ignored and original result intact. Then `rst_n` low at cycle 10 of a new RUN → `ready`=1 immediately, all outputs 0, no `done`.
